// File: rtl/des_decrypt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : des_decrypt_iter                                             |
// | Description : Iterative DES decryption engine, one Feistel round per clock.|
// |               Subkeys are produced on the fly in reverse order (K16..K1)   |
// |               by rotating C/D right, so no subkey storage is needed.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1   rising-edge clock                                    |
// |   rst        in   1   asynchronous active-high reset                       |
// |   in_valid   in   1   cipher_in/key_in valid                               |
// |   in_ready   out  1   engine idle and able to accept a block               |
// |   cipher_in  in  64   ciphertext (DES bit 1 = bit [63])                    |
// |   key_in     in  64   key incl. parity bits 8,16..64 (DES bit 1 = [63])    |
// |   out_valid  out  1   plain_out valid                                      |
// |   out_ready  in   1   downstream accepts plain_out                         |
// |   plain_out  out 64   plaintext (DES bit 1 = bit [63])                     |
// |   busy       out  1   rounds in progress or result waiting                 |
// |   key_err    out  1   key parity error (meaningful while out_valid)        |
// +----------------------------------------------------------------------------+
// | Build option: define DES_DEC_PARITY_CHECK_EN to enable the odd-parity      |
// | check of each key byte; otherwise key_err is tied low.                     |
// +----------------------------------------------------------------------------+
module des_decrypt_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain_out,
    output logic        busy,
    output logic        key_err
);

    // Permutation tables hold 1-based DES bit numbers (bit 1 = MSB).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // S1..S8, 64 entries each, indexed by {box, row[1:0], col[3:0]}.
    localparam int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,

        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,

        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,

         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,

         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,

        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,

         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,

        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    // DES bit n of a W-bit vector lives at packed index W-n.
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[5'(32 - E_T[i])];
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = x[5'(32 - P_T[i])];
        return o;
    endfunction

    // Row = outer bits (DES bits 1 and 6 of the group), column = inner four.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] g);
        return 4'(SBOX[{3'(box), g[5], g[0], g[4:1]}]);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] l_q;
    logic [31:0] r_q;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [3:0]  rnd_q;
    logic [63:0] plain_q;
    logic        key_err_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;

    logic [63:0] ip_d;
    logic [55:0] pc1_d;
    logic [47:0] subkey;
    logic [47:0] sbox_in;
    logic [31:0] sbox_out;
    logic [31:0] r_d;
    logic [27:0] c_d;
    logic [27:0] d_d;
    logic [63:0] plain_d;
    logic        key_err_d;

    // Round datapath and reverse key schedule.
    always_comb begin
        ip_d     = perm_ip(cipher_in);
        pc1_d    = perm_pc1(key_in);
        subkey   = perm_pc2({c_q, d_q});
        sbox_in  = perm_e(r_q) ^ subkey;
        sbox_out = '0;
        for (int s = 0; s < 8; s++) begin
            sbox_out[5'(31 - 4 * s) -: 4] = sbox_lookup(s, sbox_in[6'(47 - 6 * s) -: 6]);
        end
        r_d = l_q ^ perm_p(sbox_out);

        // Right rotation walks C/D backwards through the encrypt schedule;
        // the step after the last round is irrelevant, so no rotation there.
        case (rnd_q)
            4'd0, 4'd7, 4'd14: begin
                c_d = {c_q[0], c_q[27:1]};
                d_d = {d_q[0], d_q[27:1]};
            end
            4'd15: begin
                c_d = c_q;
                d_d = d_q;
            end
            default: begin
                c_d = {c_q[1:0], c_q[27:2]};
                d_d = {d_q[1:0], d_q[27:2]};
            end
        endcase

        // Output block is R16||L16; after the last round new L equals old R.
        plain_d = perm_fp({r_d, r_q});
    end

`ifdef DES_DEC_PARITY_CHECK_EN
    // Each key byte must carry odd parity; any even byte flags an error.
    always_comb begin
        key_err_d = 1'b0;
        for (int b = 0; b < 8; b++) begin
            key_err_d = key_err_d | ~(^key_in[6'(63 - 8 * b) -: 8]);
        end
    end
`else
    logic unused_key_parity;
    assign key_err_d         = 1'b0;
    assign unused_key_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                 key_in[24], key_in[16], key_in[8],  key_in[0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            rnd_q       <= '0;
            plain_q     <= '0;
            key_err_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready_q gates acceptance so the first cycle after
                    // reset release, which still shows in_ready=0, cannot load.
                    if (in_valid && in_ready_q) begin
                        l_q        <= ip_d[63:32];
                        r_q        <= ip_d[31:0];
                        c_q        <= pc1_d[55:28];
                        d_q        <= pc1_d[27:0];
                        rnd_q      <= 4'd0;
                        key_err_q  <= key_err_d;
                        state_q    <= S_ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_ROUND: begin
                    l_q   <= r_q;
                    r_q   <= r_d;
                    c_q   <= c_d;
                    d_q   <= d_d;
                    rnd_q <= rnd_q + 4'd1;
                    if (rnd_q == 4'd15) begin
                        plain_q     <= plain_d;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign plain_out = plain_q;
    assign key_err   = key_err_q;

endmodule
`default_nettype wire

// File: tb/tb_des_decrypt_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_des_decrypt_iter                                          |
// | Description : Scoreboard bench for des_decrypt_iter with directed vectors. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_des_decrypt_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] cipher_in;
    logic [63:0] key_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plain_out;
    logic        busy;
    logic        key_err;

    des_decrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain_out (plain_out),
        .busy      (busy),
        .key_err   (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DES_DEC_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] FIPS_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] FIPS_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] ZERO_KEY = 64'h0000000000000000;
    localparam logic [63:0] ZERO_CT  = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] ZERO_PT  = 64'h0000000000000000;
    localparam logic [63:0] KAT_KEY  = 64'h0101010101010101;
    localparam logic [63:0] KAT_CT   = 64'h8000000000000000;
    localparam logic [63:0] KAT_PT   = 64'h95F8A5E5DD31D900;

    typedef struct packed {
        logic [63:0] plain;
        logic        kerr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   n_push = 0;
    int   n_pop  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected no output", plain_out);
            end else begin
                mon_e = exp_q.pop_front();
                n_pop++;
                chk("plain_out", plain_out, mon_e.plain);
                chk("key_err", {63'd0, key_err}, {63'd0, mon_e.kerr});
            end
        end
    end

    // Present a block and wait for its acceptance edge; returns at edge+1.
    task automatic send(input logic [63:0] ct, input logic [63:0] key,
                        input logic [63:0] pt, input logic kerr, output int acc_cyc);
        int n;
        exp_t e;
        cipher_in = ct;
        key_in    = key;
        in_valid  = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
            acc_cyc = -1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            e.plain = pt;
            e.kerr  = kerr;
            exp_q.push_back(e);
            n_push++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        #1;
    endtask

    // Called at acceptance edge E0 + 1: out_valid must rise exactly after E16.
    task automatic check_latency();
        repeat (15) @(posedge clk);
        #1;
        chk("latency_early_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
    endtask

    int acc1;
    int acc2;
    int n_wait;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        cipher_in = '0;
        key_in    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_plain_out", plain_out, 64'd0);
        chk("rst_key_err", {63'd0, key_err}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        // FIPS vector with latency check
        send(FIPS_CT, FIPS_KEY, FIPS_PT, 1'b0, acc1);
        in_valid = 1'b0;
        chk("fips_busy", {63'd0, busy}, 64'd1);
        chk("fips_in_ready_low", {63'd0, in_ready}, 64'd0);
        check_latency();
        wait_drain();

        // Zero key: even parity in every byte
        send(ZERO_CT, ZERO_KEY, ZERO_PT, PAR_EN, acc1);
        in_valid = 1'b0;
        wait_drain();

        // Known-answer vector with noise during rounds and a long output stall
        out_ready = 1'b0;
        send(KAT_CT, KAT_KEY, KAT_PT, 1'b0, acc1);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            cipher_in = {$urandom(), $urandom()};
            key_in    = {$urandom(), $urandom()};
        end
        in_valid = 1'b0;
        n_wait = 0;
        while (out_valid !== 1'b1 && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        chk("stall_out_valid_rise", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_plain_out", plain_out, KAT_PT);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back with in_valid and out_ready held high
        send(FIPS_CT, FIPS_KEY, FIPS_PT, 1'b0, acc1);
        send(ZERO_CT, ZERO_KEY, ZERO_PT, PAR_EN, acc2);
        in_valid = 1'b0;
        chk("b2b_spacing", 64'(acc2 - acc1), 64'd18);
        wait_drain();

        // Reset in the middle of the rounds
        send(FIPS_CT, FIPS_KEY, FIPS_PT, 1'b0, acc1);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_push--;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_plain_out", plain_out, 64'd0);
        chk("midrst_key_err", {63'd0, key_err}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_output", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready_back", {63'd0, in_ready}, 64'd1);
        send(FIPS_CT, FIPS_KEY, FIPS_PT, 1'b0, acc1);
        in_valid = 1'b0;
        check_latency();
        wait_drain();

        repeat (4) @(posedge clk);
        #1;
        chk("output_count", 64'(n_pop), 64'(n_push));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
